// File: rtl/dff_pipe_if.sv
// Bus bundle for dff_pipe: advance/flush controls, input word and registered outputs.
// master drives the pipe's inputs; slave is the pipe itself.
interface dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int OCC_W = $clog2(((DEPTH < 1) ? 1 : DEPTH) + 1);

  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             out_valid;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output en, flush, in_valid, in_data,
    input  q, q_bar, out_valid, occupancy
  );

  modport slave (
    input  en, flush, in_valid, in_data,
    output q, q_bar, out_valid, occupancy
  );
endinterface

// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage stallable delay line with per-stage valids, flush, occupancy and a
// separately registered complement output. Define DFF_PIPE_ASSERT_EN to compile in checks.
module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic       clk,
  input  logic       rst,
  dff_pipe_if.slave  bus
);

  // Sizing uses a clamped depth so an illegal DEPTH still reaches the $fatal below.
  localparam int D     = (DEPTH < 1) ? 1 : DEPTH;
  localparam int OCC_W = $clog2(D + 1);

  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "dff_pipe: DEPTH must be >= 1 (got %0d)", DEPTH);
  end
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "dff_pipe: WIDTH must be >= 1 (got %0d)", WIDTH);
  end

  logic [WIDTH-1:0] data_q [D];
  logic [WIDTH-1:0] data_d [D];
  logic [D-1:0]     valid_q;
  logic [D-1:0]     valid_d;
  logic [WIDTH-1:0] q_bar_q;
  logic [WIDTH-1:0] q_bar_d;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  always_comb begin
    for (int k = 0; k < D; k++) begin
      data_d[k] = data_q[k];
    end
    valid_d = valid_q;
    occ_d   = occ_q;

    if (bus.flush) begin
      for (int k = 0; k < D; k++) begin
        data_d[k] = RESET_VAL;
      end
      valid_d = '0;
      occ_d   = '0;
    end else if (bus.en) begin
      data_d[0]  = bus.in_data;
      valid_d[0] = bus.in_valid;
      for (int k = 1; k < D; k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      // Modular arithmetic is safe: the true result always lies in 0..DEPTH.
      occ_d = occ_q + OCC_W'(bus.in_valid) - OCC_W'(valid_q[D-1]);
    end

    q_bar_d = ~data_d[D-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < D; k++) begin
        data_q[k] <= RESET_VAL;
      end
      valid_q <= '0;
      q_bar_q <= ~RESET_VAL;
      occ_q   <= '0;
    end else begin
      for (int k = 0; k < D; k++) begin
        data_q[k] <= data_d[k];
      end
      valid_q <= valid_d;
      q_bar_q <= q_bar_d;
      occ_q   <= occ_d;
    end
  end

  assign bus.q         = data_q[D-1];
  assign bus.q_bar     = q_bar_q;
  assign bus.out_valid = valid_q[D-1];
  assign bus.occupancy = occ_q;

`ifdef DFF_PIPE_ASSERT_EN
  localparam bit ASSERT_VERBOSE = 1'b0;

  A_COMPL: assert property (@(posedge clk) disable iff (rst) bus.q_bar == ~bus.q)
    begin if (ASSERT_VERBOSE) $info("A_COMPL pass at %0t", $time); end
    else $error("A_COMPL failed at %0t: q=%h q_bar=%h", $time, bus.q, bus.q_bar);

  A_OCC: assert property (@(posedge clk) disable iff (rst)
                          bus.occupancy == OCC_W'($countones(valid_q)))
    begin if (ASSERT_VERBOSE) $info("A_OCC pass at %0t", $time); end
    else $error("A_OCC failed at %0t: occupancy=%0d valids=%b", $time, bus.occupancy, valid_q);

  A_OCC_MAX: assert property (@(posedge clk) disable iff (rst) int'(bus.occupancy) <= D)
    begin if (ASSERT_VERBOSE) $info("A_OCC_MAX pass at %0t", $time); end
    else $error("A_OCC_MAX failed at %0t: occupancy=%0d", $time, bus.occupancy);

  A_HOLD: assert property (@(posedge clk) disable iff (rst)
                           !bus.en && !bus.flush |=> $stable(bus.q) && $stable(bus.occupancy))
    begin if (ASSERT_VERBOSE) $info("A_HOLD pass at %0t", $time); end
    else $error("A_HOLD failed at %0t", $time);

  A_FLUSH: assert property (@(posedge clk) disable iff (rst)
                            bus.flush |=> bus.occupancy == '0 && !bus.out_valid)
    begin if (ASSERT_VERBOSE) $info("A_FLUSH pass at %0t", $time); end
    else $error("A_FLUSH failed at %0t: occupancy=%0d out_valid=%b",
                $time, bus.occupancy, bus.out_valid);
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Directed check of dff_pipe (DEPTH=4, RESET_VAL=A5) with a DEPTH=1 twin fed the same inputs,
// followed by a seeded random run compared against a small shift-register model.
module tb_dff_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dff_pipe_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
  dff_pipe_if #(.WIDTH(8), .DEPTH(1)) bus1 ();

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hA5)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus1.en       = bus4.en;
  assign bus1.flush    = bus4.flush;
  assign bus1.in_valid = bus4.in_valid;
  assign bus1.in_data  = bus4.in_data;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] mdata [4];
  logic       mvalid [4];
  logic [7:0] m1data;
  logic       m1valid;
  logic       r_s, e_s, f_s, v_s;
  logic [7:0] d_s;
  int         occ_exp;

  // Drive one cycle of inputs, then sample 1ns after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic f,
                               input logic v, input logic [7:0] d);
    rst           = r;
    bus4.en       = e;
    bus4.flush    = f;
    bus4.in_valid = v;
    bus4.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] eq,
                             input logic ev, input logic [2:0] eo);
    n_compared++;
    assert (bus4.q === eq) else begin
      n_mismatched++;
      $error("[TB] FAIL %s q: observed %h expected %h", tag, bus4.q, eq);
    end
    n_compared++;
    assert (bus4.q_bar === ~eq) else begin
      n_mismatched++;
      $error("[TB] FAIL %s q_bar: observed %h expected %h", tag, bus4.q_bar, ~eq);
    end
    n_compared++;
    assert (bus4.out_valid === ev) else begin
      n_mismatched++;
      $error("[TB] FAIL %s out_valid: observed %b expected %b", tag, bus4.out_valid, ev);
    end
    n_compared++;
    assert (bus4.occupancy === eo) else begin
      n_mismatched++;
      $error("[TB] FAIL %s occupancy: observed %0d expected %0d", tag, bus4.occupancy, eo);
    end
  endtask

  task automatic checkD1(input string tag, input logic [7:0] eq,
                         input logic ev, input logic eo);
    n_compared++;
    assert (bus1.q === eq && bus1.q_bar === ~eq) else begin
      n_mismatched++;
      $error("[TB] FAIL %s d1 q/q_bar: observed %h/%h expected %h/%h",
             tag, bus1.q, bus1.q_bar, eq, ~eq);
    end
    n_compared++;
    assert (bus1.out_valid === ev && bus1.occupancy === eo) else begin
      n_mismatched++;
      $error("[TB] FAIL %s d1 valid/occ: observed %b/%0d expected %b/%0d",
             tag, bus1.out_valid, bus1.occupancy, ev, eo);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset for two cycles
    applyStimulus(1, 0, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 0, 8'h00);
    checkOutput("reset", 8'hA5, 0, 0);
    checkD1("reset", 8'hA5, 0, 0);

    // Latency: 01..05 back to back, then drain with bubbles
    applyStimulus(0, 1, 0, 1, 8'h01); checkOutput("lat_e1", 8'hA5, 0, 1);
    checkD1("lat_e1", 8'h01, 1, 1);
    applyStimulus(0, 1, 0, 1, 8'h02); checkOutput("lat_e2", 8'hA5, 0, 2);
    applyStimulus(0, 1, 0, 1, 8'h03); checkOutput("lat_e3", 8'hA5, 0, 3);
    applyStimulus(0, 1, 0, 1, 8'h04); checkOutput("lat_e4", 8'h01, 1, 4);
    applyStimulus(0, 1, 0, 1, 8'h05); checkOutput("lat_e5", 8'h02, 1, 4);
    checkD1("lat_e5", 8'h05, 1, 1);
    applyStimulus(0, 1, 0, 0, 8'h00); checkOutput("drain1", 8'h03, 1, 3);
    checkD1("drain1", 8'h00, 0, 0);
    applyStimulus(0, 1, 0, 0, 8'h00); checkOutput("drain2", 8'h04, 1, 2);
    applyStimulus(0, 1, 0, 0, 8'h00); checkOutput("drain3", 8'h05, 1, 1);
    applyStimulus(0, 1, 0, 0, 8'h00); checkOutput("drain4", 8'h00, 0, 0);

    // Stall with two words in flight; inputs during stall must be ignored
    applyStimulus(0, 1, 0, 1, 8'h11); checkOutput("stall_ld1", 8'h00, 0, 1);
    applyStimulus(0, 1, 0, 1, 8'h22); checkOutput("stall_ld2", 8'h00, 0, 2);
    checkD1("stall_ld2", 8'h22, 1, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, 8'h99);
      checkOutput("stall_hold", 8'h00, 0, 2);
      checkD1("stall_hold", 8'h22, 1, 1);
    end
    applyStimulus(0, 1, 0, 0, 8'h00); checkOutput("resume1", 8'h00, 0, 2);
    applyStimulus(0, 1, 0, 0, 8'h00); checkOutput("resume2", 8'h11, 1, 2);
    applyStimulus(0, 1, 0, 0, 8'h00); checkOutput("resume3", 8'h22, 1, 1);
    applyStimulus(0, 1, 0, 0, 8'h00); checkOutput("resume4", 8'h00, 0, 0);

    // Bubbles: valid 1,0,1,0
    applyStimulus(0, 1, 0, 1, 8'hAA); checkOutput("bub_e1", 8'h00, 0, 1);
    applyStimulus(0, 1, 0, 0, 8'hFF); checkOutput("bub_e2", 8'h00, 0, 1);
    applyStimulus(0, 1, 0, 1, 8'hBB); checkOutput("bub_e3", 8'h00, 0, 2);
    applyStimulus(0, 1, 0, 0, 8'hFF); checkOutput("bub_e4", 8'hAA, 1, 2);
    applyStimulus(0, 1, 0, 0, 8'h00); checkOutput("bub_e5", 8'hFF, 0, 1);
    applyStimulus(0, 1, 0, 0, 8'h00); checkOutput("bub_e6", 8'hBB, 1, 1);
    applyStimulus(0, 1, 0, 0, 8'h00); checkOutput("bub_e7", 8'hFF, 0, 0);

    // Fill, then flush with en=1 and a valid word that must be discarded
    applyStimulus(0, 1, 0, 1, 8'h31); checkOutput("fill1", 8'h00, 0, 1);
    applyStimulus(0, 1, 0, 1, 8'h32); checkOutput("fill2", 8'h00, 0, 2);
    applyStimulus(0, 1, 0, 1, 8'h33); checkOutput("fill3", 8'h00, 0, 3);
    applyStimulus(0, 1, 0, 1, 8'h34); checkOutput("fill4", 8'h31, 1, 4);
    applyStimulus(0, 1, 1, 1, 8'h77); checkOutput("flush", 8'hA5, 0, 0);
    checkD1("flush", 8'hA5, 0, 0);
    applyStimulus(0, 1, 0, 0, 8'h00); checkOutput("post_flush1", 8'hA5, 0, 0);
    applyStimulus(0, 1, 0, 0, 8'h00); checkOutput("post_flush2", 8'hA5, 0, 0);
    applyStimulus(0, 1, 0, 0, 8'h00); checkOutput("post_flush3", 8'hA5, 0, 0);
    applyStimulus(0, 1, 0, 0, 8'h00); checkOutput("post_flush4", 8'h00, 0, 0);

    // Reset and flush together mid-stream
    applyStimulus(0, 1, 0, 1, 8'h41); checkOutput("rf_ld1", 8'h00, 0, 1);
    applyStimulus(0, 1, 0, 1, 8'h42); checkOutput("rf_ld2", 8'h00, 0, 2);
    applyStimulus(1, 1, 1, 1, 8'h55); checkOutput("rst_flush", 8'hA5, 0, 0);
    checkD1("rst_flush", 8'hA5, 0, 0);
    applyStimulus(0, 0, 0, 1, 8'h66); checkOutput("rst_hold", 8'hA5, 0, 0);
    checkD1("rst_hold", 8'hA5, 0, 0);

    // Random run against a reference shift model
    for (int k = 0; k < 4; k++) begin
      mdata[k]  = 8'hA5;
      mvalid[k] = 1'b0;
    end
    m1data  = 8'hA5;
    m1valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      r_s = ($urandom_range(0, 39) == 0);
      f_s = ($urandom_range(0, 15) == 0);
      e_s = ($urandom_range(0, 3) != 0);
      v_s = ($urandom_range(0, 2) != 0);
      d_s = 8'($urandom_range(0, 255));
      if (r_s || f_s) begin
        for (int k = 0; k < 4; k++) begin
          mdata[k]  = 8'hA5;
          mvalid[k] = 1'b0;
        end
        m1data  = 8'hA5;
        m1valid = 1'b0;
      end else if (e_s) begin
        for (int k = 3; k > 0; k--) begin
          mdata[k]  = mdata[k-1];
          mvalid[k] = mvalid[k-1];
        end
        mdata[0]  = d_s;
        mvalid[0] = v_s;
        m1data    = d_s;
        m1valid   = v_s;
      end
      applyStimulus(r_s, e_s, f_s, v_s, d_s);
      occ_exp = 0;
      for (int k = 0; k < 4; k++) begin
        if (mvalid[k]) occ_exp++;
      end
      checkOutput("rand", mdata[3], mvalid[3], 3'(occ_exp));
      checkD1("rand", m1data, m1valid, m1valid);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
